// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative integer multiply/divide unit (RISC-V M-extension ops).
// One operand bit is processed per CALC cycle. Multiply uses shift-add and
// divide uses restoring shift-subtract. Sign correction is applied on exit.
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   in_valid / in_ready      request handshake (SrcA, SrcB, Operation)
//   kill                     synchronous abort, highest priority
//   out_valid / out_ready    result handshake (ALUResult)
//   busy                     high whenever the unit is not IDLE
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [OP_WIDTH-1:0]   Operation,
    input  logic                  kill,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  busy
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(7);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [OP_WIDTH-1:0]   op_q, op_d;
    logic                  a_neg_q, a_neg_d;
    logic                  b_neg_q, b_neg_d;
    logic [W-1:0]          a_mag_q, a_mag_d;
    logic [W-1:0]          b_mag_q, b_mag_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [W-1:0]          quot_q, quot_d;
    logic [W-1:0]          rem_q, rem_d;
    logic [W-1:0]          result_q, result_d;

    // Request decode: signedness, magnitudes and the two bypass cases
    logic                  in_is_div, in_is_rem;
    logic                  in_a_signed, in_b_signed;
    logic                  in_a_neg, in_b_neg;
    logic [W-1:0]          in_a_mag, in_b_mag;
    logic                  in_div0, in_ovf, in_bypass;
    logic [W-1:0]          in_bypass_res;

    always_comb begin
        in_is_div   = (Operation == OP_DIV) || (Operation == OP_DIVU) ||
                      (Operation == OP_REM) || (Operation == OP_REMU);
        in_is_rem   = (Operation == OP_REM) || (Operation == OP_REMU);
        in_a_signed = (Operation == OP_MULH) || (Operation == OP_MULHSU) ||
                      (Operation == OP_DIV)  || (Operation == OP_REM);
        in_b_signed = (Operation == OP_MULH) || (Operation == OP_DIV) ||
                      (Operation == OP_REM);
        in_a_neg    = in_a_signed && SrcA[W-1];
        in_b_neg    = in_b_signed && SrcB[W-1];
        in_a_mag    = in_a_neg ? W'(-SrcA) : SrcA;
        in_b_mag    = in_b_neg ? W'(-SrcB) : SrcB;
        in_div0     = in_is_div && (SrcB == '0);
        in_ovf      = ((Operation == OP_DIV) || (Operation == OP_REM)) &&
                      (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        in_bypass   = in_div0 || in_ovf;
        if (in_div0) begin
            in_bypass_res = in_is_rem ? SrcA : '1;
        end else begin
            in_bypass_res = in_is_rem ? '0 : SrcA;
        end
    end

    // One iteration step of each datapath, plus sign-corrected final results
    logic                  op_is_mul;
    logic [W-1:0]          mul_add;
    logic [W:0]            mul_sum;
    logic [PW-1:0]         acc_step;
    logic [W:0]            div_trial;
    logic                  div_fits;
    logic [W-1:0]          div_diff;
    logic [W-1:0]          rem_step, quot_step;
    logic [PW-1:0]         prod_fin;
    logic [W-1:0]          quot_fin, rem_fin, calc_res;
    logic                  unused_acc_lsb;

    assign unused_acc_lsb = acc_q[0];

    always_comb begin
        op_is_mul = (op_q == OP_MUL) || (op_q == OP_MULH) ||
                    (op_q == OP_MULHSU) || (op_q == OP_MULHU);
        // Multiplier LSB gates the add into the upper half, then shift right
        mul_add   = b_mag_q[0] ? a_mag_q : '0;
        mul_sum   = {1'b0, acc_q[PW-1:W]} + {1'b0, mul_add};
        acc_step  = {mul_sum, acc_q[W-1:1]};
        // Dividend bits stream out of quot_q MSB-first into the partial remainder
        div_trial = {rem_q, quot_q[W-1]};
        div_fits  = div_trial >= {1'b0, b_mag_q};
        div_diff  = div_trial[W-1:0] - b_mag_q;
        rem_step  = div_fits ? div_diff : div_trial[W-1:0];
        quot_step = {quot_q[W-2:0], div_fits};

        prod_fin  = (a_neg_q ^ b_neg_q) ? PW'(-acc_step) : acc_step;
        quot_fin  = (a_neg_q ^ b_neg_q) ? W'(-quot_step) : quot_step;
        rem_fin   = a_neg_q ? W'(-rem_step) : rem_step;

        if (op_q == OP_MUL) begin
            calc_res = prod_fin[W-1:0];
        end else if (op_is_mul) begin
            calc_res = prod_fin[PW-1:W];
        end else if ((op_q == OP_REM) || (op_q == OP_REMU)) begin
            calc_res = rem_fin;
        end else begin
            calc_res = quot_fin;
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && !kill) begin
                    op_d    = Operation;
                    a_neg_d = in_a_neg;
                    b_neg_d = in_b_neg;
                    a_mag_d = in_a_mag;
                    b_mag_d = in_b_mag;
                    acc_d   = '0;
                    quot_d  = in_a_mag;
                    rem_d   = '0;
                    cnt_d   = CW'(W - 1);
                    if (in_bypass) begin
                        state_d  = DONE;
                        result_d = in_bypass_res;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (op_is_mul) begin
                    acc_d   = acc_step;
                    b_mag_d = b_mag_q >> 1;
                end else begin
                    quot_d  = quot_step;
                    rem_d   = rem_step;
                end
                if (cnt_q == '0) begin
                    cnt_d    = '0;
                    state_d  = DONE;
                    result_d = calc_res;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d  = IDLE;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                result_d = '0;
            end
        endcase

        // Abort wins over acceptance and over the output handshake
        if (kill) begin
            state_d  = IDLE;
            result_d = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    // Status decodes straight from the state register; result is zero outside DONE
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign ALUResult = result_q;

endmodule
